// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and freeze controller for a 5-stage in-order pipeline.
// Detects load-use hazards in ID against the load sitting in ID/EX, resolves
// taken branches from EX/MEM, honours an external freeze (memory busy) and a
// debug halt/single-step FSM. Stall and flush events are counted in
// saturating counters.
//
// Ports
//   clk            in   1      single clock, rising edge
//   reset          in   1      asynchronous, active-high reset
//   id_rs1/id_rs2  in   5      source registers of the instruction in ID
//   id_uses_rs2    in   1      ID instruction actually reads rs2
//   ex_rd          in   5      destination of the ID/EX instruction
//   ex_memread     in   1      ID/EX instruction is a load
//   mem_branch     in   1      EX/MEM instruction is a branch
//   mem_taken      in   1      its condition resolved true
//   ext_hold       in   1      external freeze request
//   dbg_halt       in   1      debug halt level
//   dbg_step       in   1      single-step pulse (sampled in HALT)
//   cnt_clr        in   1      synchronous clear of both counters
//   pipe_en        out  1      enable for all pipeline registers
//   pc_write       out  1      PC load enable
//   if_id_write    out  1      IF/ID load enable
//   id_ex_bubble   out  1      load zeros into ID/EX controls
//   if_id_flush    out  1      clear IF/ID
//   id_ex_flush    out  1      clear ID/EX
//   ex_mem_flush   out  1      clear EX/MEM
//   pc_src         out  1      select branch target for the PC
//   state          out  2      debug FSM state (RUN/HALT/STEP)
//   stall_cnt      out  CNT_W  load-use stall cycles (saturating)
//   flush_cnt      out  CNT_W  branch flush cycles (saturating)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_branch,
    input  logic             mem_taken,
    input  logic             ext_hold,
    input  logic             dbg_halt,
    input  logic             dbg_step,
    input  logic             cnt_clr,
    output logic             pipe_en,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             pc_src,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    logic hz;
    logic tk;
    logic adv;
    logic stall_ev;
    logic flush_ev;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // reads. x0 is never a real dependency.
    assign hz = ex_memread && (ex_rd != 5'd0) &&
                ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    assign tk = mem_branch && mem_taken;

    // Reset forces every control output low even though the FSM already
    // sits in RUN, so the pipeline cannot advance while reset is held.
    assign adv = !reset && !ext_hold && ((state_q == RUN) || (state_q == STEP));

    assign stall_ev = adv && !tk && hz;
    assign flush_ev = adv && tk;

    // Control outputs: purely combinational from the current state and inputs.
    // A taken branch wins over a load-use stall because the stalled
    // instruction is on the wrong path and is flushed anyway.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        pipe_en      = adv;
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = 1'b0;

        if (adv) begin
            if (tk) begin
                pc_src       = 1'b1;
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (hz) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    // Debug FSM next state. A step is consumed only by a cycle in which the
    // pipeline actually advances; a stall cycle still counts as that step.
    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN:  state_d = dbg_halt ? HALT : RUN;
            HALT: begin
                if (!dbg_halt)     state_d = RUN;
                else if (dbg_step) state_d = STEP;
                else               state_d = HALT;
            end
            STEP: begin
                if (adv) state_d = dbg_halt ? HALT : RUN;
                else     state_d = STEP;
            end
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    assign state = state_q;

    // Saturating event counters; clear takes priority over an increment.
    // NOTE: the counters are architecturally visible, so they are reset
    // explicitly rather than left to power-up contents.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of the stall and flush event counters.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: id_rs1, id_rs2  input  5 each  source register fields of the instruction in ID.
REQ-005 SHALL have port: id_uses_rs2  input  1  the ID instruction reads rs2 (R/S/B-type).
REQ-006 SHALL have ports: ex_rd  input  5  destination of the ID/EX instruction; ex_memread  input  1  ID/EX instruction is a load.
REQ-007 SHALL have ports: mem_branch  input  1  EX/MEM instruction is a branch; mem_taken  input  1  its condition resolved true.
REQ-008 SHALL have ports: ext_hold  input  1  external freeze request (memory busy); dbg_halt  input  1  debug halt level; dbg_step  input  1  single-step pulse; cnt_clr  input  1  synchronous counter clear.
REQ-009 SHALL have ports: pipe_en  output  1  enable for all pipeline registers; pc_write  output  1  PC load enable; if_id_write  output  1  IF/ID load enable.
REQ-010 SHALL have ports: id_ex_bubble  output  1  load zeros into ID/EX controls; if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  clear the stage; pc_src  output  1  select branch target for the PC.
REQ-011 SHALL have ports: state  output  2  FSM state; stall_cnt, flush_cnt  output  CNT_W each  event counters.

Function
REQ-012 SHALL implement FSM states RUN=2'b00, HALT=2'b01, STEP=2'b10; 2'b11 SHALL return to RUN on the next edge.
REQ-013 SHALL define hz = ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
REQ-014 SHALL define tk = mem_branch && mem_taken.
REQ-015 SHALL define adv = !ext_hold && (state==RUN || state==STEP); pipe_en = adv, combinational.
REQ-016 When adv=0: pc_write, if_id_write, id_ex_bubble, all flushes and pc_src SHALL be 0.
REQ-017 When adv && tk: pc_src=1, pc_write=1, if_id_write=1, if_id_flush=id_ex_flush=ex_mem_flush=1, id_ex_bubble=0 (branch priority over load-use).
REQ-018 When adv && !tk && hz: pc_write=0, if_id_write=0, id_ex_bubble=1, flushes=0, pc_src=0.
REQ-019 When adv && !tk && !hz: pc_write=1, if_id_write=1, all other control outputs 0.
REQ-020 All outputs of REQ-016..019 SHALL be combinational from state and current inputs (zero-cycle latency).
REQ-021 RUN: dbg_halt=1 -> HALT next cycle; the current cycle still behaves as RUN.
REQ-022 HALT: dbg_halt=0 -> RUN; else dbg_step=1 -> STEP; else stay HALT.
REQ-023 STEP: if adv=1, next state HALT when dbg_halt=1, else RUN; if ext_hold=1, stay STEP (step consumed only by an advancing cycle).
REQ-024 A load-use stall cycle in STEP SHALL count as the consumed step.
REQ-025 stall_cnt SHALL increment on each cycle with adv && !tk && hz; flush_cnt on each cycle with adv && tk.
REQ-026 Counters SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-027 cnt_clr SHALL zero both counters on the next edge, taking priority over increment; it SHALL not affect the FSM.

Reset
REQ-028 While reset=1: state=RUN, stall_cnt=0, flush_cnt=0, and pipe_en, pc_write, if_id_write, id_ex_bubble, flushes, pc_src all 0, regardless of inputs.
REQ-029 Reset asserted mid-HALT or mid-STEP SHALL abort immediately; after release the block SHALL start in RUN.

Verification
REQ-030 Load-use: RUN, ex_memread=1, ex_rd=5, id_rs1=5 -> pc_write=0, if_id_write=0, id_ex_bubble=1 same cycle; stall_cnt 0->1.
REQ-031 No false stall: ex_memread=1, ex_rd=0, id_rs1=0; then ex_rd=7, id_rs2=7, id_uses_rs2=0 -> id_ex_bubble=0, pc_write=1 in both cases.
REQ-032 Branch+hazard: tk=1 and hz=1 same cycle -> pc_src=1, three flushes=1, id_ex_bubble=0; flush_cnt+1, stall_cnt unchanged.
REQ-033 Debug: dbg_halt=1 in RUN -> state=HALT next cycle, pipe_en=0; one-cycle dbg_step -> exactly one cycle with pipe_en=1 (state=STEP), then HALT.
REQ-034 Hold in STEP: ext_hold=1 for 3 cycles -> pipe_en=0, state stays STEP; ext_hold=0 -> one advancing cycle, then HALT.
REQ-035 Saturation/reset: CNT_W=4, 20 stall cycles -> stall_cnt=15; reset pulse while state=HALT -> state=RUN, both counters 0.
